// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the FFT twiddle fetch block.
// Holds the default sizes, the twiddle_t record carried through the skid FIFO,
// the fetch FSM state type and two small helpers (stage base address,
// saturating negation used by the conjugate build).
package fft_pkg;

  localparam int DEF_N_STAGES = 5;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 16;
  localparam int TW_STAGE_W   = (DEF_N_STAGES > 1) ? $clog2(DEF_N_STAGES) : 1;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] re;
    logic [DEF_DATA_W-1:0] im;
    logic [TW_STAGE_W-1:0] stage;
    logic                  last;
  } twiddle_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Stage s occupies 2^s ROM entries starting at 2^s - 1. The same value is
  // also the mask that folds the in-stage read index onto j.
  function automatic logic [DEF_ADDR_W-1:0] stage_base(input logic [TW_STAGE_W-1:0] s);
    return DEF_ADDR_W'((32'd1 << s) - 32'd1);
  endfunction

  // Two's-complement negation that maps the most-negative code to the
  // most-positive one instead of wrapping back onto itself.
  function automatic logic [DEF_DATA_W-1:0] neg_sat(input logic [DEF_DATA_W-1:0] x);
    if (x == {1'b1, {(DEF_DATA_W-1){1'b0}}})
      return {1'b0, {(DEF_DATA_W-1){1'b1}}};
    return -x;
  endfunction

endpackage

// File: rtl/fft_twiddle_fetch_if.sv
// fft_twiddle_fetch_if -- ROM read port plus twiddle valid/ready stream.
//   rom_addr/rom_en            : read request to both twiddle ROMs
//   rom_re_data/rom_im_data    : ROM outputs, valid one cycle after rom_en
//   tw_valid/tw_ready          : twiddle stream handshake
//   tw_re/tw_im/tw_stage/tw_last : twiddle payload
// master = the fetch block, slave = ROM pair + butterfly side.
interface fft_twiddle_fetch_if
  import fft_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int STAGE_W = TW_STAGE_W
);
  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_en;
  logic [DATA_W-1:0]  rom_re_data;
  logic [DATA_W-1:0]  rom_im_data;
  logic               tw_valid;
  logic               tw_ready;
  logic [DATA_W-1:0]  tw_re;
  logic [DATA_W-1:0]  tw_im;
  logic [STAGE_W-1:0] tw_stage;
  logic               tw_last;

  modport master (
    output rom_addr, rom_en, tw_valid, tw_re, tw_im, tw_stage, tw_last,
    input  rom_re_data, rom_im_data, tw_ready
  );

  modport slave (
    input  rom_addr, rom_en, tw_valid, tw_re, tw_im, tw_stage, tw_last,
    output rom_re_data, rom_im_data, tw_ready
  );
endinterface

// File: rtl/twiddle_skid_fifo.sv
// twiddle_skid_fifo -- 2-entry FIFO of twiddle_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, push_data : write one entry (ignored when full unless popping)
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (stable until popped)
//   count      : occupancy 0..2, used by the parent for read credit
module twiddle_skid_fifo
  import fft_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  twiddle_t push_data,
  input  logic     pop,
  output twiddle_t head,
  output logic [1:0] count
);

  twiddle_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;
  logic     do_push;
  logic     do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fft_twiddle_fetch.sv
// fft_twiddle_fetch -- twiddle ROM read sequencer for the radix-2 DIT FFT.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a transform (ignored while busy)
//   busy       : transform in progress
//   done       : one-cycle pulse after the final twiddle handshake
//   bus        : fft_twiddle_fetch_if.master (ROM read port + twiddle stream)
// Build option: define TWIDDLE_CONJ_EN to present the conjugate twiddle
// (saturating negation of the ROM imaginary part) for the inverse FFT.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, counters at zero
// ST_ISSUE | issuing ROM reads as credit allows
// ST_DRAIN | all reads issued, waiting for the tw_last handshake
module fft_twiddle_fetch
  import fft_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  fft_twiddle_fetch_if.master bus
);

  localparam int K_W = (N_STAGES > 1) ? N_STAGES - 1 : 1;
  localparam int S_W = TW_STAGE_W;
  localparam logic [S_W-1:0] LAST_STAGE = S_W'(N_STAGES - 1);
  localparam logic [K_W-1:0] LAST_K     = K_W'((1 << (N_STAGES - 1)) - 1);

  fetch_state_t   state;
  logic [S_W-1:0] stage_q;
  logic [K_W-1:0] k_q;          // read index inside the stage, 0..N/2-1
  logic           pend_q;       // read issued last cycle, data on ROM outputs now
  logic [S_W-1:0] pend_stage;
  logic           pend_last;

  logic [1:0]        fifo_count;
  twiddle_t          head;
  twiddle_t          push_data;
  logic [DATA_W-1:0] im_fixed;
  logic [2:0]        load;
  logic              pop;
  logic              issue;
  logic              issue_last;

  assign pop = bus.tw_valid && bus.tw_ready;

  // Occupancy after this cycle's pop plus the read returning this cycle.
  // Counting the pop lets the pipeline sustain one twiddle per cycle while
  // never holding more than two entries buffered or in flight.
  assign load  = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, pop};
  assign issue = (state == ST_ISSUE) && (load < 3'd2);

  assign issue_last = (stage_q == LAST_STAGE) && (k_q == LAST_K);

  // Address = base + (k mod 2^s); the group index never needs storing.
  // Counters wrap to zero after the last read, so rom_addr only moves on
  // edges that completed a read.
  assign bus.rom_en   = issue;
  assign bus.rom_addr = ADDR_W'(stage_base(stage_q)) +
                        (ADDR_W'(k_q) & ADDR_W'(stage_base(stage_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      stage_q    <= '0;
      k_q        <= '0;
      pend_q     <= 1'b0;
      pend_stage <= '0;
      pend_last  <= 1'b0;
    end else begin
      done   <= 1'b0;
      pend_q <= issue;
      if (issue) begin
        pend_stage <= stage_q;
        pend_last  <= issue_last;
        if (k_q == LAST_K) begin
          k_q     <= '0;
          stage_q <= issue_last ? '0 : stage_q + S_W'(1);
        end else begin
          k_q <= k_q + K_W'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue && issue_last)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && head.last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TWIDDLE_CONJ_EN
  assign im_fixed = neg_sat(bus.rom_im_data);
`else
  assign im_fixed = bus.rom_im_data;
`endif

  always_comb begin
    push_data       = '0;
    push_data.re    = bus.rom_re_data;
    push_data.im    = im_fixed;
    push_data.stage = pend_stage;
    push_data.last  = pend_last;
  end

  twiddle_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.tw_valid = (fifo_count != 2'd0);
  assign bus.tw_re    = head.re;
  assign bus.tw_im    = head.im;
  assign bus.tw_stage = head.stage;
  assign bus.tw_last  = head.last;

endmodule

// File: tb/tb_fft_twiddle_fetch.sv
// tb_fft_twiddle_fetch -- scoreboard bench for fft_twiddle_fetch.
// A reference model expands the stage/group/j loops into the expected address
// and twiddle queues; a negedge monitor drives tw_ready and pops/compares.
module tb_fft_twiddle_fetch;
  import fft_pkg::*;

  localparam int NS    = DEF_N_STAGES;
  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int SW    = TW_STAGE_W;
  localparam int NPTS  = 1 << NS;
  localparam int TOTAL = NS * NPTS / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  fft_twiddle_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .STAGE_W(SW)) bus ();

  fft_twiddle_fetch #(.N_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  // ROM pair with registered output
  logic [DW-1:0] rom_re [1<<AW];
  logic [DW-1:0] rom_im [1<<AW];
  always @(posedge clk) begin
    if (bus.rom_en) begin
      bus.rom_re_data <= rom_re[bus.rom_addr];
      bus.rom_im_data <= rom_im[bus.rom_addr];
    end
  end

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            stage;
    bit            last;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] im_ref(input logic [DW-1:0] x);
`ifdef TWIDDLE_CONJ_EN
    int v;
    v = -$signed(x);
    if (v > 32767) v = 32767;
    return v[DW-1:0];
`else
    return x;
`endif
  endfunction

  task automatic fill_rom();
    for (int a = 0; a < (1 << AW); a++) begin
      rom_re[a] = DW'($urandom);
      rom_im[a] = DW'($urandom);
    end
    rom_im[9]  = 16'hFF4A;
    rom_im[20] = 16'h8000;
  endtask

  task automatic load_expect();
    exp_q.delete();
    addr_q.delete();
    for (int s = 0; s < NS; s++)
      for (int g = 0; g < (NPTS >> (s + 1)); g++)
        for (int j = 0; j < (1 << s); j++) begin
          int a;
          exp_t e;
          a       = (1 << s) - 1 + j;
          e.re    = rom_re[a[AW-1:0]];
          e.im    = im_ref(rom_im[a[AW-1:0]]);
          e.stage = s;
          e.last  = (s == NS - 1) && (g == (NPTS >> (s + 1)) - 1) && (j == (1 << s) - 1);
          exp_q.push_back(e);
          addr_q.push_back(a);
        end
  endtask

  // monitor state
  int  mode = 0;          // 0: ready held high, 1: random ready
  int  stall_left = 0;
  int  hs_count = 0;
  int  cyc = 0;
  int  first_hs_cyc = 0;
  int  last_hs_cyc = 0;
  int  done_cnt = 0;
  int  issued = 0;
  int  accepted = 0;
  bit  expect_done = 0;
  bit  prev_stall = 0;
  logic [DW-1:0] held_re, held_im;
  logic [SW-1:0] held_st;
  logic          held_last;
  logic [DW-1:0] cap_im [TOTAL];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic rdy;
    exp_t e;
    if (!rst_n) begin
      bus.tw_ready = 1'b0;
      prev_stall   = 0;
    end else begin
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (mode == 0) begin
        rdy = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      bus.tw_ready = rdy;
      #1;
      check("done", 64'(done), 64'(expect_done));
      if (done) begin
        done_cnt++;
        check("busy_with_done", 64'(busy), 64'(0));
      end
      expect_done = 0;
      check("outstanding_le_2", 64'((issued - accepted) <= 2), 64'(1));
      if (prev_stall) begin
        check("stall_valid", 64'(bus.tw_valid), 64'(1));
        check("stall_re", 64'(bus.tw_re), 64'(held_re));
        check("stall_im", 64'(bus.tw_im), 64'(held_im));
        check("stall_stage", 64'(bus.tw_stage), 64'(held_st));
        check("stall_last", 64'(bus.tw_last), 64'(held_last));
      end
      if (bus.rom_en) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_read: addr %0d issued, none expected", bus.rom_addr);
        end else begin
          check("rom_addr", 64'(bus.rom_addr), 64'(addr_q.pop_front()));
        end
        issued++;
      end
      if (bus.tw_valid && bus.tw_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_twiddle: re %0h im %0h, none expected", bus.tw_re, bus.tw_im);
        end else begin
          e = exp_q.pop_front();
          check("tw_re", 64'(bus.tw_re), 64'(e.re));
          check("tw_im", 64'(bus.tw_im), 64'(e.im));
          check("tw_stage", 64'(bus.tw_stage), 64'(e.stage));
          check("tw_last", 64'(bus.tw_last), 64'(e.last));
          if (e.last) expect_done = 1;
        end
        if (hs_count < TOTAL) cap_im[hs_count] = bus.tw_im;
        if (hs_count == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_count++;
        accepted++;
      end
      prev_stall = bus.tw_valid && !bus.tw_ready;
      held_re    = bus.tw_re;
      held_im    = bus.tw_im;
      held_st    = bus.tw_stage;
      held_last  = bus.tw_last;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     64'(busy), 64'(0));
    check({tag, "_done"},     64'(done), 64'(0));
    check({tag, "_rom_en"},   64'(bus.rom_en), 64'(0));
    check({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'(0));
    check({tag, "_valid"},    64'(bus.tw_valid), 64'(0));
    check({tag, "_last"},     64'(bus.tw_last), 64'(0));
    check({tag, "_re"},       64'(bus.tw_re), 64'(0));
    check({tag, "_im"},       64'(bus.tw_im), 64'(0));
    check({tag, "_stage"},    64'(bus.tw_stage), 64'(0));
  endtask

  // Pulses start (sampled at edge T) and checks the first-read/first-valid timing.
  task automatic run_start();
    fill_rom();
    load_expect();
    hs_count = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;           // just after T
    check("lat_busy", 64'(busy), 64'(1));
    check("lat_rom_en", 64'(bus.rom_en), 64'(1));
    check("lat_rom_addr", 64'(bus.rom_addr), 64'(0));
    check("lat_valid_t1", 64'(bus.tw_valid), 64'(0));
    @(posedge clk); #2;                        // after T+1
    check("lat_valid_t2", 64'(bus.tw_valid), 64'(0));
    @(posedge clk); #2;                        // after T+2
    check("lat_valid_t3", 64'(bus.tw_valid), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    int target;
    int i;
    target = done_cnt + 1;
    for (i = 0; i < 3000 && done_cnt < target; i++) @(posedge clk);
    check({tag, "_done_seen"}, 64'(done_cnt >= target), 64'(1));
    #2;
    check({tag, "_handshakes"}, 64'(hs_count), 64'(TOTAL));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_hs(input int n);
    int i;
    for (i = 0; i < 3000 && hs_count < n; i++) @(posedge clk);
    check("reach_handshake", 64'(hs_count >= n), 64'(1));
  endtask

  initial begin
    int dc;
    bus.tw_ready    = 1'b0;
    bus.rom_re_data = '0;
    bus.rom_im_data = '0;
    fill_rom();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;

    // run 1: ready held high, full-rate stream
    mode = 0;
    run_start();
    wait_done("run1");
    check("run1_throughput", 64'(last_hs_cyc - first_hs_cyc), 64'(TOTAL - 1));
    check("run1_done_count", 64'(done_cnt), 64'(1));
`ifdef TWIDDLE_CONJ_EN
    check("stage3_j2_im", 64'(cap_im[50]), 64'(16'h00B6));
    check("sat_neg_im", 64'(cap_im[69]), 64'(16'h7FFF));
`else
    check("stage3_j2_im", 64'(cap_im[50]), 64'(16'hFF4A));
    check("raw_8000_im", 64'(cap_im[69]), 64'(16'h8000));
`endif

    // run 2: random backpressure, 10-cycle stall, start re-pulsed while busy
    mode = 1;
    run_start();
    wait_hs(20);
    stall_left = 10;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done("run2");
    repeat (6) @(posedge clk);
    #2;
    check("run2_idle_busy", 64'(busy), 64'(0));
    check("run2_done_count", 64'(done_cnt), 64'(2));

    // run 3: reset at handshake 30 aborts, then a clean transform
    run_start();
    wait_hs(30);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    addr_q.delete();
    issued      = 0;
    accepted    = 0;
    expect_done = 0;
    dc          = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("abort_no_done", 64'(done_cnt), 64'(dc));
    run_start();
    wait_done("run3");
    check("run3_done_count", 64'(done_cnt), 64'(dc + 1));

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_twiddle_fetch.md
# fft_twiddle_fetch

Twiddle-factor read sequencer for the radix-2 DIT FFT datapath. It drives the read address of the real and imaginary twiddle ROMs, which have a 1-cycle registered output. It absorbs the ROM read latency and presents one complex twiddle per butterfly to the butterfly unit over a valid/ready stream. It sits between the twiddle ROM pair and the butterfly scheduler, and runs once per transform on a `start` pulse.

## Interface
- `N_STAGES`, default 5: FFT stages; N = 2^N_STAGES points.
- `ADDR_W`, default 5: ROM address width; must satisfy 2^ADDR_W ≥ 2^N_STAGES − 1.
- `DATA_W`, default 16: twiddle component width, two's complement.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; begins a transform; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the final twiddle handshake.
- `rom_addr` out ADDR_W: address to both ROMs.
- `rom_en` out 1: a read is issued this cycle.
- `rom_re_data` in DATA_W: real ROM output, valid 1 cycle after `rom_en`.
- `rom_im_data` in DATA_W: imaginary ROM output, valid 1 cycle after `rom_en`.
- `tw_valid` out 1: twiddle available.
- `tw_ready` in 1: butterfly accepts the twiddle.
- `tw_re`, `tw_im` out DATA_W: twiddle components.
- `tw_stage` out clog2(N_STAGES): stage index of the presented twiddle.
- `tw_last` out 1: last twiddle of the transform.

## Operation
- ROM layout: stage s uses 2^s entries at base address 2^s − 1, so twiddle j of stage s is at address 2^s − 1 + j.
- Issue order per stage s, for s = 0..N_STAGES−1:
  - Outer loop: groups g = 0..N/2^(s+1) − 1.
  - Inner loop: j = 0..2^s − 1.
  - Each stage issues N/2 reads, so a transform issues N_STAGES·N/2 reads (80 for defaults).
- FSM states:
  - IDLE: `start` → ISSUE.
  - ISSUE: all reads issued → DRAIN.
  - DRAIN: FIFO empty and final handshake done → IDLE, with `done` pulsed on that transition.
- Credit rule: `rom_en` may assert only when (FIFO occupancy + reads in flight) < 2. At most 2 twiddles are ever buffered or outstanding.
- Returned ROM data, `tw_stage` and `tw_last` are pushed into a 2-entry FIFO. Stage and last tags travel through a 1-cycle delay matched to the ROM latency.
- The FIFO head drives the `tw_*` outputs.
- A handshake (`tw_valid & tw_ready`) pops one entry. A push and a pop in the same cycle are both honoured.
- Backpressure never drops or duplicates a twiddle. `rom_addr` holds its value while `rom_en` is low.
- `start` during `busy` has no effect.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=0, `tw_valid`=0, `tw_last`=0.
  - `tw_re`, `tw_im`, `tw_stage` = 0.
  - FSM in IDLE, FIFO empty, counters cleared.
- Reset asserted mid-transform aborts immediately. No `done` is produced for the aborted transform.
- Latency, with `start` sampled at edge T:
  - `rom_en` and `rom_addr` = 0 become valid after edge T.
  - First `tw_valid` asserts after edge T+2.
- Throughput: with `tw_ready` held high, one twiddle per cycle after the first, so the 80 handshakes complete on consecutive cycles.
- `done` asserts the cycle after the handshake carrying `tw_last`. `busy` falls in the same cycle `done` is high.
- `tw_*` stay stable while `tw_valid & ~tw_ready`.

## Configuration
- `TWIDDLE_CONJ_EN` defined: `tw_im` is the negated ROM imaginary part, i.e. the conjugate twiddle for the inverse FFT.
  - Negation saturates: most-negative → most-positive (16'h8000 → 16'h7FFF).
  - Negation is applied at FIFO push and adds no latency.
- `TWIDDLE_CONJ_EN` undefined: `tw_im` equals `rom_im_data` unmodified.

## Structure
- Shared package `fft_pkg` holds:
  - `N_STAGES`, `DATA_W` and `ADDR_W` defaults.
  - A `twiddle_t` struct {re, im, stage, last}.
  - A stage-base address function returning 2^s − 1.
- Sub-module `twiddle_skid_fifo`: a 2-entry FIFO of `twiddle_t` with push/pop, `count` output and asynchronous active-low reset. The credit logic in the parent uses its `count`.

## Test plan
- Reset, then `start` with `tw_ready`=1:
  - Stage 0 presents 16 twiddles from address 0.
  - Stage 1 addresses alternate 1, 2 (8 pairs).
  - Stage 4 addresses run 15..30 once.
  - 80 handshakes total; `tw_last` on the 80th; `done` one cycle later.
- ROM model returning 16'hFF4A at address 9: a stage-3 twiddle with j=2 gives `tw_im`=16'hFF4A (without `TWIDDLE_CONJ_EN`).
- `tw_ready` low for 10 cycles mid-stage:
  - Never more than 2 outstanding reads.
  - No lost or repeated twiddle.
  - Outputs stable during the stall.
- `start` re-pulsed while `busy`: ignored, still exactly 80 handshakes.
- `rst_n` asserted at handshake 30: all outputs 0 immediately. A fresh `start` then yields a full 80-twiddle sequence from address 0.
- With `TWIDDLE_CONJ_EN`: ROM imag 16'hFF4A → `tw_im`=16'h00B6; 16'h8000 → 16'h7FFF.
